// File: rtl/md_motion_pkg.sv
// rtl/md_motion_pkg.sv - shared state, packing order and pack/unpack helpers for motion-update broadcast
package md_motion_pkg;

  localparam int MD_DATA_WIDTH    = 32;
  localparam int MD_CELL_ID_WIDTH = 4;

  // Slot index (from LSB) of each coordinate in a {z,y,x} word and a {x,y,z} cell word
  localparam int POS_X_SLOT  = 0;
  localparam int POS_Y_SLOT  = 1;
  localparam int POS_Z_SLOT  = 2;
  localparam int CELL_X_SLOT = 2;
  localparam int CELL_Y_SLOT = 1;
  localparam int CELL_Z_SLOT = 0;

  typedef logic [MD_DATA_WIDTH-1:0]    coord_t;
  typedef logic [MD_CELL_ID_WIDTH-1:0] cell_id_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_NUM,
    ST_LATCH_NUM,
    ST_READ_PART,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  function automatic logic [3*MD_DATA_WIDTH-1:0] pack_zyx(input coord_t x, input coord_t y, input coord_t z);
    logic [3*MD_DATA_WIDTH-1:0] r;
    r = '0;
    r[POS_X_SLOT*MD_DATA_WIDTH +: MD_DATA_WIDTH] = x;
    r[POS_Y_SLOT*MD_DATA_WIDTH +: MD_DATA_WIDTH] = y;
    r[POS_Z_SLOT*MD_DATA_WIDTH +: MD_DATA_WIDTH] = z;
    return r;
  endfunction

  function automatic coord_t unpack_zyx(input logic [3*MD_DATA_WIDTH-1:0] v, input int slot);
    return v[slot*MD_DATA_WIDTH +: MD_DATA_WIDTH];
  endfunction

  function automatic logic [3*MD_CELL_ID_WIDTH-1:0] pack_xyz(input cell_id_t x, input cell_id_t y, input cell_id_t z);
    logic [3*MD_CELL_ID_WIDTH-1:0] r;
    r = '0;
    r[CELL_X_SLOT*MD_CELL_ID_WIDTH +: MD_CELL_ID_WIDTH] = x;
    r[CELL_Y_SLOT*MD_CELL_ID_WIDTH +: MD_CELL_ID_WIDTH] = y;
    r[CELL_Z_SLOT*MD_CELL_ID_WIDTH +: MD_CELL_ID_WIDTH] = z;
    return r;
  endfunction

  function automatic cell_id_t unpack_xyz(input logic [3*MD_CELL_ID_WIDTH-1:0] v, input int slot);
    return v[slot*MD_CELL_ID_WIDTH +: MD_CELL_ID_WIDTH];
  endfunction

endpackage

// File: rtl/motion_update_broadcaster_if.sv
// rtl/motion_update_broadcaster_if.sv - cache read port plus motion-update broadcast bus
interface motion_update_broadcaster_if
  import md_motion_pkg::*;
#(
  parameter int DATA_WIDTH    = MD_DATA_WIDTH,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = MD_CELL_ID_WIDTH
);
  logic                       rd_en;
  logic [ADDR_WIDTH-1:0]      rd_address;
  logic [3*DATA_WIDTH-1:0]    pos_rd_data;
  logic [3*DATA_WIDTH-1:0]    disp_rd_data;
  logic                       motion_update_enable;
  logic [3*DATA_WIDTH-1:0]    out_data;
  logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell;
  logic                       out_data_valid;

  modport master (
    output rd_en, rd_address, motion_update_enable, out_data, out_data_dst_cell, out_data_valid,
    input  pos_rd_data, disp_rd_data
  );

  modport slave (
    input  rd_en, rd_address, motion_update_enable, out_data, out_data_dst_cell, out_data_valid,
    output pos_rd_data, disp_rd_data
  );
endinterface

// File: rtl/motion_update_dst_calc.sv
// rtl/motion_update_dst_calc.sv - per-coordinate periodic add and 1-based destination cell index
module motion_update_dst_calc #(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int CELL_BITS     = 2
) (
  input  logic [DATA_WIDTH-1:0]    pos,
  input  logic [DATA_WIDTH-1:0]    disp,
  output logic [DATA_WIDTH-1:0]    new_pos,
  output logic [CELL_ID_WIDTH-1:0] dst_cell
);
  // Modular wrap of the sum is the periodic boundary; negative displacements arrive as two's complement
  assign new_pos  = pos + disp;
  assign dst_cell = CELL_ID_WIDTH'(new_pos[DATA_WIDTH-1 -: CELL_BITS]) + CELL_ID_WIDTH'(1);
endmodule

// File: rtl/motion_update_broadcaster.sv
// rtl/motion_update_broadcaster.sv - reads one cell's particles, applies displacement, broadcasts updates
module motion_update_broadcaster
  import md_motion_pkg::*;
#(
  parameter int DATA_WIDTH    = MD_DATA_WIDTH,
  parameter int PARTICLE_NUM  = 220,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = MD_CELL_ID_WIDTH,
  parameter int CELL_BITS     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  motion_update_broadcaster_if.master bus,
  output logic busy,
  output logic done
);
  localparam logic [ADDR_WIDTH-1:0] PART_MAX = ADDR_WIDTH'(PARTICLE_NUM);

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr, addr_n;
  logic [ADDR_WIDTH-1:0]   count, count_n;
  logic                    drain_cnt, drain_n;
  logic [ADDR_WIDTH-1:0]   raw_count;

  logic                    rd_en_c;
  logic [ADDR_WIDTH-1:0]   rd_addr_c;
  logic                    enable_c;
  logic                    busy_c;
  logic                    done_c;

  logic                    s2_valid;
  logic                    out_valid_q;
  logic [3*DATA_WIDTH-1:0] out_data_q;
  logic [3*CELL_ID_WIDTH-1:0] out_cell_q;

  logic [DATA_WIDTH-1:0]    new_c [3];
  logic [CELL_ID_WIDTH-1:0] dst_c [3];

  assign raw_count = bus.pos_rd_data[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      count     <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      count     <= count_n;
      drain_cnt <= drain_n;
    end
  end

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    count_n   = count;
    drain_n   = drain_cnt;
    rd_en_c   = 1'b0;
    rd_addr_c = '0;
    enable_c  = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_n = ST_READ_NUM;
      end
      ST_READ_NUM: begin
        rd_en_c  = 1'b1;
        enable_c = 1'b1;
        busy_c   = 1'b1;
        state_n  = ST_LATCH_NUM;
      end
      ST_LATCH_NUM: begin
        enable_c = 1'b1;
        busy_c   = 1'b1;
        count_n  = (raw_count > PART_MAX) ? PART_MAX : raw_count;
        addr_n   = ADDR_WIDTH'(1);
        state_n  = (raw_count == '0) ? ST_FINISH : ST_READ_PART;
      end
      ST_READ_PART: begin
        rd_en_c   = 1'b1;
        rd_addr_c = addr;
        enable_c  = 1'b1;
        busy_c    = 1'b1;
        addr_n    = addr + ADDR_WIDTH'(1);
        if (addr == count) begin
          state_n = ST_DRAIN;
          drain_n = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Enable stays up until the last beat has left the output register
        enable_c = 1'b1;
        busy_c   = 1'b1;
        drain_n  = 1'b1;
        if (drain_cnt) state_n = ST_FINISH;
      end
      ST_FINISH: begin
        done_c  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < 3; i++) begin : g_coord
    motion_update_dst_calc #(
      .DATA_WIDTH   (DATA_WIDTH),
      .CELL_ID_WIDTH(CELL_ID_WIDTH),
      .CELL_BITS    (CELL_BITS)
    ) u_calc (
      .pos     (unpack_zyx(bus.pos_rd_data, i)),
      .disp    (unpack_zyx(bus.disp_rd_data, i)),
      .new_pos (new_c[i]),
      .dst_cell(dst_c[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cell_q  <= '0;
    end else begin
      s2_valid    <= (state == ST_READ_PART);
      out_valid_q <= s2_valid;
      out_data_q  <= s2_valid ? pack_zyx(new_c[POS_X_SLOT], new_c[POS_Y_SLOT], new_c[POS_Z_SLOT]) : '0;
      out_cell_q  <= s2_valid ? pack_xyz(dst_c[POS_X_SLOT], dst_c[POS_Y_SLOT], dst_c[POS_Z_SLOT]) : '0;
    end
  end

  assign bus.rd_en                = rd_en_c;
  assign bus.rd_address           = rd_addr_c;
  assign bus.motion_update_enable = enable_c;
  assign bus.out_data             = out_data_q;
  assign bus.out_data_dst_cell    = out_cell_q;
  assign bus.out_data_valid       = out_valid_q;
  assign busy                     = busy_c;
  assign done                     = done_c;
endmodule
